// File: rtl/tdc_readout_arbiter_pkg.sv
// Shared types and constants for the TDC readout arbiter.
package TDCArbiterPackage;

  typedef enum logic [1:0] {STATE_ARB, STATE_SEND, STATE_DROP} arb_state_t;

  localparam int unsigned DROP_COUNT_WIDTH = 16;
  localparam logic [DROP_COUNT_WIDTH-1:0] DROP_COUNT_MAX = '1;

  function automatic logic [DROP_COUNT_WIDTH-1:0] drop_count_next(
    input logic [DROP_COUNT_WIDTH-1:0] value
  );
    return (value == DROP_COUNT_MAX) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/tdc_readout_arbiter_picker.sv
// Round-robin find-first: first set request after ptr, wrapping, ending at ptr itself.
module rr_priority_picker #(
  parameter int unsigned CHANNEL_COUNT = 2,
  localparam int unsigned CH_ID_WIDTH = $clog2(CHANNEL_COUNT)
) (
  input  logic [CHANNEL_COUNT-1:0] req,
  input  logic [CH_ID_WIDTH-1:0]   ptr,
  output logic                     found,
  output logic [CH_ID_WIDTH-1:0]   index
);

  localparam int Count = int'(CHANNEL_COUNT);

  logic [2*CHANNEL_COUNT-1:0] dbl_req;
  int                         pos;

  always_comb begin
    dbl_req = {req, req};
    found   = 1'b0;
    index   = '0;
    pos     = 0;
    // Upper copy lets the scan run past the top without wrapping logic; reduce afterwards.
    for (int j = 1; j <= Count; j++) begin
      pos = int'(ptr) + j;
      if (!found && dbl_req[pos]) begin
        found = 1'b1;
        index = (pos >= Count) ? CH_ID_WIDTH'(pos - Count) : CH_ID_WIDTH'(pos);
      end
    end
  end

endmodule

// File: rtl/tdc_readout_arbiter.sv
// Round-robin arbiter sharing one event port among TDC channels; drains disabled channels.
module tdc_readout_arbiter
  import TDCArbiterPackage::*;
#(
  parameter int unsigned CHANNEL_COUNT = 2,
  parameter int unsigned DATA_WIDTH    = 32,
  localparam int unsigned CH_ID_WIDTH  = $clog2(CHANNEL_COUNT)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [CHANNEL_COUNT-1:0]            enable_channels,
  input  logic [CHANNEL_COUNT-1:0]            ch_valid,
  input  logic [CHANNEL_COUNT*DATA_WIDTH-1:0] ch_data,
  output logic [CHANNEL_COUNT-1:0]            ch_ack,
  output logic                                out_valid,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic [CH_ID_WIDTH-1:0]              out_channel,
  input  logic                                out_ready,
  output logic [DROP_COUNT_WIDTH-1:0]         drop_count,
  output logic                                busy
);

  arb_state_t               state;
  logic [CH_ID_WIDTH-1:0]   ptr;
  logic [CHANNEL_COUNT-1:0] eligible;
  logic [CHANNEL_COUNT-1:0] stale;
  logic                     found;
  logic [CH_ID_WIDTH-1:0]   sel;
  logic [CH_ID_WIDTH-1:0]   stale_idx;
  logic [DATA_WIDTH-1:0]    sel_data;

  assign eligible = ch_valid & enable_channels;
  assign stale    = ch_valid & ~enable_channels;
  assign busy     = (state != STATE_ARB);

  rr_priority_picker #(
    .CHANNEL_COUNT(CHANNEL_COUNT)
  ) u_picker (
    .req  (eligible),
    .ptr  (ptr),
    .found(found),
    .index(sel)
  );

  always_comb begin
    stale_idx = '0;
    for (int i = int'(CHANNEL_COUNT) - 1; i >= 0; i--) begin
      if (stale[i]) stale_idx = CH_ID_WIDTH'(i);
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < int'(CHANNEL_COUNT); i++) begin
      if (CH_ID_WIDTH'(i) == sel) sel_data = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= STATE_ARB;
      ptr         <= CH_ID_WIDTH'(CHANNEL_COUNT - 1);
      ch_ack      <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_channel <= '0;
      drop_count  <= '0;
    end else begin
      case (state)
        STATE_ARB: begin
          ch_ack <= '0;
          if (found) begin
            out_data    <= sel_data;
            out_channel <= sel;
            out_valid   <= 1'b1;
            ch_ack[sel] <= 1'b1;
            ptr         <= sel;
            state       <= STATE_SEND;
          end else if (|stale) begin
            ch_ack[stale_idx] <= 1'b1;
            drop_count        <= drop_count_next(drop_count);
            state             <= STATE_DROP;
          end
        end
        STATE_SEND: begin
          ch_ack <= '0;
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= STATE_ARB;
          end
        end
        STATE_DROP: begin
          // One dead cycle so the buffer can retire the popped word before rearbitration.
          ch_ack <= '0;
          state  <= STATE_ARB;
        end
        default: begin
          ch_ack <= '0;
          state  <= STATE_ARB;
        end
      endcase
    end
  end

endmodule
